// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Contents:
//   parity_e      - parity mode encoding (none / odd / even)
//   tx_state_e    - transmitter frame states
//   clks_per_bit  - rounded clock-cycles-per-bit from clock and baud rate
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Rounded division, so the bit period is as close as possible to 1/baud
  function automatic int clks_per_bit(input int freq, input int baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// Synchronous single-clock FIFO, reusable by both UART directions.
// Ports:
//   clk     in   clock
//   rst     in   synchronous reset, active-high (flushes contents)
//   push    in   write wr_data (ignored while full)
//   wr_data in   WIDTH  word to store
//   pop     in   remove the head word (ignored while empty)
//   rd_data out  WIDTH  head word, valid while not empty
//   full    out  occupancy == DEPTH
//   empty   out  occupancy == 0
//   count   out  $clog2(DEPTH)+1  current occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign count   = occ;
  assign rd_data = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is not reset: only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); the extra occupancy
  // bit is what tells full apart from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by a FIFO with a valid/ready handshake.
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous reset, active-high
//   data_i   in   DATA_BITS  word to transmit
//   valid_i  in   producer offers data_i
//   ready_o  out  FIFO can accept a word
//   tx_o     out  serial line, idle high, registered
//   busy_o   out  frame in progress or FIFO non-empty
//   count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FREQ       = 27_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_BITS-1:0]          data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int      CPB   = clks_per_bit(FREQ, BAUD);
  localparam int      CW    = (CPB > 2) ? $clog2(CPB) : 1;
  localparam parity_e PMODE = parity_e'(PARITY);

  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  tx_state_e              state, state_next;
  logic [CW-1:0]          baud_cnt, baud_next;
  logic [2:0]             bit_idx, idx_next;
  logic [DATA_BITS-1:0]   shreg, shreg_next;
  logic                   par_q, par_next;
  logic                   tx_q, tx_next;
  logic                   pop;
  logic                   bit_end;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (valid_i),
    .wr_data (data_i),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign ready_o = !fifo_full;
  assign count_o = fifo_count;
  assign tx_o    = tx_q;
  assign busy_o  = (state != ST_IDLE) || !fifo_empty;
  assign bit_end = (baud_cnt == CW'(CPB - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= idx_next;
      shreg    <= shreg_next;
      par_q    <= par_next;
      tx_q     <= tx_next;
    end
  end

  // tx_next is always the line level of the bit that starts after the edge,
  // which keeps tx_o a plain register. Loading a word also precomputes its
  // parity bit; the final stop cycle may reload directly for back-to-back frames.
  always_comb begin
    state_next = state;
    baud_next  = bit_end ? '0 : baud_cnt + 1'b1;
    idx_next   = bit_idx;
    shreg_next = shreg;
    par_next   = par_q;
    tx_next    = tx_q;
    pop        = 1'b0;

    case (state)
      ST_IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_next = fifo_head;
          par_next   = (^fifo_head) ^ (PMODE == PAR_ODD);
          idx_next   = '0;
          tx_next    = 1'b0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          idx_next   = '0;
          tx_next    = shreg[0];
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            idx_next = '0;
            if (PMODE != PAR_NONE) begin
              tx_next    = par_q;
              state_next = ST_PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = ST_STOP;
            end
          end else begin
            idx_next   = bit_idx + 3'd1;
            shreg_next = shreg >> 1;
            tx_next    = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          idx_next   = '0;
          tx_next    = 1'b1;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            idx_next = '0;
            if (!fifo_empty) begin
              pop        = 1'b1;
              shreg_next = fifo_head;
              par_next   = (^fifo_head) ^ (PMODE == PAR_ODD);
              tx_next    = 1'b0;
              state_next = ST_START;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            idx_next = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. Three instances share one clock and
// reset: 8N1, 8E1 and 5O2, all at 4 clocks per bit with a 4-entry FIFO.
// A frame-level reference model (queue of accepted words plus position
// inside the current frame) predicts tx_o, ready_o, busy_o and count_o.
module tb_uart_tx_fifo;

  localparam int FREQ  = 460800;
  localparam int BAUD  = 115200;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [2:0]    v   = '0;
  logic [7:0]    d [3];
  logic [2:0]    rdy;
  logic [2:0]    txo;
  logic [2:0]    bsy;
  logic [CW-1:0] cnt [3];

  int tests = 0;
  int fails = 0;

  uart_tx_fifo #(
    .FREQ (FREQ), .BAUD (BAUD), .DATA_BITS (8), .PARITY (0),
    .STOP_BITS (1), .FIFO_DEPTH (DEPTH)
  ) u_8n1 (
    .clk_i (clk), .rst_i (rst), .data_i (d[0]), .valid_i (v[0]),
    .ready_o (rdy[0]), .tx_o (txo[0]), .busy_o (bsy[0]), .count_o (cnt[0])
  );

  uart_tx_fifo #(
    .FREQ (FREQ), .BAUD (BAUD), .DATA_BITS (8), .PARITY (2),
    .STOP_BITS (1), .FIFO_DEPTH (DEPTH)
  ) u_8e1 (
    .clk_i (clk), .rst_i (rst), .data_i (d[1]), .valid_i (v[1]),
    .ready_o (rdy[1]), .tx_o (txo[1]), .busy_o (bsy[1]), .count_o (cnt[1])
  );

  uart_tx_fifo #(
    .FREQ (FREQ), .BAUD (BAUD), .DATA_BITS (5), .PARITY (1),
    .STOP_BITS (2), .FIFO_DEPTH (DEPTH)
  ) u_5o2 (
    .clk_i (clk), .rst_i (rst), .data_i (d[2][4:0]), .valid_i (v[2]),
    .ready_o (rdy[2]), .tx_o (txo[2]), .busy_o (bsy[2]), .count_o (cnt[2])
  );

  // Per-instance frame configuration
  function automatic int db(input int i);
    return (i == 2) ? 5 : 8;
  endfunction

  function automatic int pm(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic int sb(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic int flen(input int i);
    return CPB * (1 + db(i) + ((pm(i) != 0) ? 1 : 0) + sb(i));
  endfunction

  // Line levels of a whole frame, one entry per bit period
  function automatic logic [15:0] build(input int i, input logic [7:0] w);
    logic [15:0] f;
    int ones;
    f    = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int k = 0; k < db(i); k++) begin
      f[1 + k] = w[k];
      ones += int'(w[k]);
    end
    if (pm(i) == 1) f[1 + db(i)] = (ones % 2 == 0);
    if (pm(i) == 2) f[1 + db(i)] = (ones % 2 == 1);
    return f;
  endfunction

  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];
  logic [7:0]  q2 [$];
  int          pos [3] = '{-1, -1, -1};
  logic [15:0] fb  [3];

  function automatic int msize(input int i);
    if (i == 0) return q0.size();
    if (i == 1) return q1.size();
    return q2.size();
  endfunction

  task automatic mpop(input int i, output logic [7:0] w);
    if (i == 0) w = q0.pop_front();
    else if (i == 1) w = q1.pop_front();
    else w = q2.pop_front();
  endtask

  task automatic mpush(input int i, input logic [7:0] w);
    if (i == 0) q0.push_back(w);
    else if (i == 1) q1.push_back(w);
    else q2.push_back(w & 8'h1F);
  endtask

  task automatic mclear(input int i);
    if (i == 0) q0.delete();
    else if (i == 1) q1.delete();
    else q2.delete();
  endtask

  // Advance one instance's model by one clock edge using pre-edge inputs
  task automatic modelStep(input int i);
    int pre;
    logic [7:0] w;
    logic acc;
    if (rst) begin
      mclear(i);
      pos[i] = -1;
      return;
    end
    pre = msize(i);
    acc = v[i] && (pre != DEPTH);
    if (pos[i] < 0 || pos[i] == flen(i) - 1) begin
      if (pre > 0) begin
        mpop(i, w);
        fb[i]  = build(i, w);
        pos[i] = 0;
      end else begin
        pos[i] = -1;
      end
    end else begin
      pos[i] = pos[i] + 1;
    end
    if (acc) mpush(i, d[i]);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) modelStep(i);
  end

  task automatic chk(input string tag, input int i, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h at %0t", tag, i, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic e_tx;
    int   e_cnt;
    for (int i = 0; i < 3; i++) begin
      e_cnt = msize(i);
      e_tx  = (pos[i] < 0) ? 1'b1 : fb[i][pos[i] / CPB];
      chk("tx_o", i, {7'd0, txo[i]}, {7'd0, e_tx});
      chk("count_o", i, 8'(cnt[i]), 8'(e_cnt));
      chk("ready_o", i, {7'd0, rdy[i]}, {7'd0, e_cnt != DEPTH});
      chk("busy_o", i, {7'd0, bsy[i]}, {7'd0, (pos[i] >= 0) || (e_cnt != 0)});
    end
  endtask

  // Inputs are already set by the caller; run one edge and check at negedge
  task automatic applyStimulus(input logic r);
    rst = r;
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    v = '0;
    for (int c = 0; c < n; c++) applyStimulus(1'b0);
  endtask

  task automatic sendOne(input logic [7:0] w);
    for (int i = 0; i < 3; i++) d[i] = w;
    v = 3'b111;
    applyStimulus(1'b0);
    idleCycles(60);
  endtask

  int  k [3];
  logic [2:0] acc;

  initial begin
    for (int i = 0; i < 3; i++) d[i] = '0;
    @(negedge clk);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    $display("[TB] reset checked");

    sendOne(8'h55);
    sendOne(8'h07);
    sendOne(8'h1F);
    sendOne(8'hE3);

    // Burst: hold valid with A0..A5, advancing each instance on acceptance
    for (int i = 0; i < 3; i++) k[i] = 0;
    for (int c = 0; c < 330; c++) begin
      for (int i = 0; i < 3; i++) begin
        v[i]   = (k[i] < 6);
        d[i]   = 8'hA0 + 8'(k[i]);
        acc[i] = v[i] && (msize(i) != DEPTH);
      end
      applyStimulus(1'b0);
      for (int i = 0; i < 3; i++) if (acc[i]) k[i]++;
    end
    for (int i = 0; i < 3; i++) begin
      chk("burst_words_accepted", i, 8'(k[i]), 8'd6);
    end

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        v[i] = ($urandom_range(0, 2) == 0);
        d[i] = 8'($urandom);
      end
      applyStimulus(1'b0);
    end
    idleCycles(300);

    // Reset during data bit 3 with two words queued behind the active frame
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) d[i] = 8'h3C + 8'(j);
      v = 3'b111;
      applyStimulus(1'b0);
    end
    v = '0;
    for (int c = 0; c < 16; c++) applyStimulus(1'b0);
    applyStimulus(1'b1);
    idleCycles(80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
